// File: rtl/duty_slew_limiter.sv
// duty_slew_limiter: slew-rate limits the raw duty command before it reaches
// the PWM generator. Duty moves by at most STEP LSB once every RATE_DIV
// clocks, and drops to 0 immediately when enable goes low.
//
// Handshake: none. enable is a level, target_value is a free-running level
// that is only looked at on rate ticks (and on the OFF->RAMP cycle).
module duty_slew_limiter #(
  parameter int N        = 10,
  parameter int STEP     = 4,
  parameter int RATE_DIV = 1024,
  parameter int DUTY_MAX = 1023
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [N-1:0] target_value,
  output logic [N-1:0] duty_value,
  output logic         ramping,
  output logic         at_target
);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RAMP = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam int            TW        = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(RATE_DIV - 1);
  localparam logic [N-1:0]  DMAX      = N'(DUTY_MAX);
  localparam logic [N:0]    STEP_W    = (N+1)'(STEP);
  localparam logic [N-1:0]  STEP_N    = N'(STEP);

  state_t        state, state_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [N-1:0]  tgt, tgt_nx;
  logic [N-1:0]  duty_nx;
  logic          ramping_nx, at_target_nx;

  logic          tick;
  logic [N-1:0]  t_clamp;
  logic [N-1:0]  t_use;
  logic          go_up, go_dn;
  logic [N:0]    diff_up, diff_dn, mag;
  logic [N-1:0]  step_n;

  // Rate tick and the clamped target; T is the fresh sample on a tick.
  assign tick    = (state != S_OFF) && (tcnt == TCNT_LAST);
  assign t_clamp = (target_value > DMAX) ? DMAX : target_value;
  assign t_use   = tick ? t_clamp : tgt;

  // Distance to target at N+1 bits so neither direction can wrap.
  assign go_up   = (t_use > duty_value);
  assign go_dn   = (t_use < duty_value);
  assign diff_up = {1'b0, t_use} - {1'b0, duty_value};
  assign diff_dn = {1'b0, duty_value} - {1'b0, t_use};
  assign mag     = go_up ? diff_up : diff_dn;
  assign step_n  = (mag > STEP_W) ? STEP_N : mag[N-1:0];

  // State, counter, target and output registers; async reset to OFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_OFF;
      tcnt       <= '0;
      tgt        <= '0;
      duty_value <= '0;
      ramping    <= 1'b0;
      at_target  <= 1'b0;
    end else begin
      state      <= state_nx;
      tcnt       <= tcnt_nx;
      tgt        <= tgt_nx;
      duty_value <= duty_nx;
      ramping    <= ramping_nx;
      at_target  <= at_target_nx;
    end
  end

  // Next-state logic: disable wins over everything, steps only on ticks.
  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt;
    tgt_nx   = tgt;
    duty_nx  = duty_value;

    if (!enable) begin
      state_nx = S_OFF;
      tcnt_nx  = '0;
      duty_nx  = '0;
    end else begin
      case (state)
        S_OFF: begin
          state_nx = S_RAMP;
          tgt_nx   = t_clamp;
          tcnt_nx  = '0;
          duty_nx  = '0;
        end
        S_RAMP, S_HOLD: begin
          tcnt_nx = tick ? '0 : tcnt + TW'(1);
          if (tick) begin
            tgt_nx = t_clamp;
            if (go_up)      duty_nx = duty_value + step_n;
            else if (go_dn) duty_nx = duty_value - step_n;
            state_nx = (duty_nx == t_use) ? S_HOLD : S_RAMP;
          end
        end
        default: begin
          state_nx = S_OFF;
          tcnt_nx  = '0;
          duty_nx  = '0;
        end
      endcase
    end

    ramping_nx   = (state_nx == S_RAMP);
    at_target_nx = (state_nx == S_HOLD);
  end

endmodule

// File: tb/tb_duty_slew_limiter.sv
// Self-checking bench for duty_slew_limiter with a short rate period.
module tb_duty_slew_limiter;

  localparam int N        = 10;
  localparam int STEP     = 4;
  localparam int RATE_DIV = 8;
  localparam int DUTY_MAX = 900;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [N-1:0] target_value;
  logic [N-1:0] duty_value;
  logic         ramping;
  logic         at_target;

  int errors = 0;
  int checks = 0;

  // Reference model: duty only moves every RATE_DIV edges after enabling.
  int m_on, m_edges, m_duty, m_ramp, m_hold;

  logic [N-1:0] exp_q[$];

  duty_slew_limiter #(
    .N(N), .STEP(STEP), .RATE_DIV(RATE_DIV), .DUTY_MAX(DUTY_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .target_value(target_value),
    .duty_value(duty_value),
    .ramping(ramping),
    .at_target(at_target)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic model_reset();
    m_on = 0; m_edges = 0; m_duty = 0; m_ramp = 0; m_hold = 0;
  endtask

  task automatic model_edge();
    int t;
    if (rst) begin
      model_reset();
    end else if (!enable) begin
      model_reset();
    end else if (m_on == 0) begin
      m_on = 1; m_edges = 0; m_ramp = 1; m_hold = 0;
    end else begin
      m_edges++;
      if (m_edges % RATE_DIV == 0) begin
        t = (int'(target_value) > DUTY_MAX) ? DUTY_MAX : int'(target_value);
        if (t > m_duty)      m_duty += ((t - m_duty) < STEP) ? (t - m_duty) : STEP;
        else if (t < m_duty) m_duty -= ((m_duty - t) < STEP) ? (m_duty - t) : STEP;
        m_hold = (m_duty == t) ? 1 : 0;
        m_ramp = 1 - m_hold;
      end
    end
  endtask

  // One clock: advance model on the edge, compare 1 time unit later.
  task automatic step();
    logic [31:0] md;
    @(posedge clk);
    model_edge();
    #1;
    md = m_duty;
    checks++;
    if (duty_value !== md[N-1:0]) begin
      errors++;
      if (errors <= 30) $display("FAIL model_duty t=%0t got=%0d exp=%0d", $time, duty_value, m_duty);
    end
    checks++;
    if (ramping !== (m_ramp != 0)) begin
      errors++;
      if (errors <= 30) $display("FAIL model_ramping t=%0t got=%0b exp=%0b", $time, ramping, m_ramp);
    end
    checks++;
    if (at_target !== (m_hold != 0)) begin
      errors++;
      if (errors <= 30) $display("FAIL model_at_target t=%0t got=%0b exp=%0b", $time, at_target, m_hold);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (duty_value !== '0 || ramping !== 1'b0 || at_target !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got duty=%0d ramp=%0b hold=%0b exp 0/0/0", duty_value, ramping, at_target);
    end
    run(2);
    rst = 1'b0;
    run(3);
  endtask

  task automatic test_soft_start();
    enable = 1'b1;
    target_value = 10'd1023;
    step();
    checks++;
    if (ramping !== 1'b1 || duty_value !== '0) begin
      errors++;
      $display("FAIL soft_start_entry got duty=%0d ramp=%0b exp 0/1", duty_value, ramping);
    end
    exp_q.delete();
    for (int k = 1; k * STEP < DUTY_MAX + STEP; k++)
      exp_q.push_back((k * STEP > DUTY_MAX) ? N'(DUTY_MAX) : N'(k * STEP));
    while (exp_q.size() > 0) begin
      logic [N-1:0] e;
      e = exp_q.pop_front();
      run(RATE_DIV);
      checks++;
      if (duty_value !== e) begin
        errors++;
        if (errors <= 30) $display("FAIL soft_start_tick got=%0d exp=%0d", duty_value, e);
      end
    end
    run(3 * RATE_DIV);
    checks++;
    if (duty_value !== 10'd900 || at_target !== 1'b1) begin
      errors++;
      $display("FAIL clamp_hold got duty=%0d hold=%0b exp 900/1", duty_value, at_target);
    end
  endtask

  task automatic test_partial_step();
    int i;
    target_value = 10'd100;
    for (i = 0; i < 2000 && !(m_hold != 0 && m_duty == 100); i++) step();
    checks++;
    if (i >= 2000) begin
      errors++;
      $display("FAIL partial_reach_timeout got duty=%0d exp 100", duty_value);
    end
    target_value = 10'd102;
    run(RATE_DIV);
    checks++;
    if (duty_value !== 10'd102 || at_target !== 1'b1) begin
      errors++;
      $display("FAIL partial_up got duty=%0d hold=%0b exp 102/1", duty_value, at_target);
    end
    target_value = 10'd99;
    run(RATE_DIV);
    checks++;
    if (duty_value !== 10'd99 || at_target !== 1'b1) begin
      errors++;
      $display("FAIL partial_down got duty=%0d hold=%0b exp 99/1", duty_value, at_target);
    end
  endtask

  task automatic test_reversal();
    int d;
    enable = 1'b0;
    step();
    enable = 1'b1;
    target_value = 10'd1023;
    step();
    run(50 * RATE_DIV);
    checks++;
    if (duty_value !== 10'd200 || ramping !== 1'b1) begin
      errors++;
      $display("FAIL reversal_start got duty=%0d ramp=%0b exp 200/1", duty_value, ramping);
    end
    target_value = 10'd150;
    exp_q.delete();
    d = 200;
    while (d != 150) begin
      d = (d - 150 > STEP) ? d - STEP : 150;
      exp_q.push_back(N'(d));
    end
    while (exp_q.size() > 0) begin
      logic [N-1:0] e;
      e = exp_q.pop_front();
      run(RATE_DIV);
      checks++;
      if (duty_value !== e) begin
        errors++;
        if (errors <= 30) $display("FAIL reversal_tick got=%0d exp=%0d", duty_value, e);
      end
    end
    checks++;
    if (at_target !== 1'b1 || ramping !== 1'b0) begin
      errors++;
      $display("FAIL reversal_hold got hold=%0b ramp=%0b exp 1/0", at_target, ramping);
    end
  endtask

  task automatic test_disable();
    enable = 1'b0;
    step();
    enable = 1'b1;
    target_value = 10'd1023;
    step();
    run(75 * RATE_DIV + 3);
    checks++;
    if (duty_value !== 10'd300) begin
      errors++;
      $display("FAIL disable_pre got duty=%0d exp 300", duty_value);
    end
    enable = 1'b0;
    step();
    checks++;
    if (duty_value !== '0 || ramping !== 1'b0) begin
      errors++;
      $display("FAIL disable_drop got duty=%0d ramp=%0b exp 0/0", duty_value, ramping);
    end
    enable = 1'b1;
    step();
    run(RATE_DIV - 1);
    checks++;
    if (duty_value !== '0) begin
      errors++;
      $display("FAIL reenable_early got duty=%0d exp 0", duty_value);
    end
    step();
    checks++;
    if (duty_value !== 10'd4) begin
      errors++;
      $display("FAIL reenable_first_step got duty=%0d exp 4", duty_value);
    end
  endtask

  task automatic test_enable_toggle();
    target_value = 10'd1023;
    enable = 1'b0;
    step();
    for (int i = 0; i < 40; i++) begin
      enable = 1'b1;
      run($urandom_range(1, RATE_DIV - 1));
      checks++;
      if (duty_value !== '0) begin
        errors++;
        $display("FAIL toggle_nonzero got duty=%0d exp 0", duty_value);
      end
      enable = 1'b0;
      run($urandom_range(1, 3));
    end
  endtask

  task automatic test_random();
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) target_value = N'($urandom_range(0, 1023));
      if ($urandom_range(0, 199) == 0) begin
        enable = 1'b0;
        run($urandom_range(1, 20));
        enable = 1'b1;
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b1;
    target_value = 10'd1023;
    run(5 * RATE_DIV + 3);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (duty_value !== '0 || ramping !== 1'b0 || at_target !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got duty=%0d ramp=%0b hold=%0b exp 0/0/0", duty_value, ramping, at_target);
    end
    run(2);
    enable = 1'b0;
    #2;
    rst = 1'b0;
    step();
    checks++;
    if (duty_value !== '0 || ramping !== 1'b0 || at_target !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_off got duty=%0d ramp=%0b hold=%0b exp 0/0/0", duty_value, ramping, at_target);
    end
    enable = 1'b1;
    step();
    run(RATE_DIV);
    checks++;
    if (duty_value !== 10'd4 || ramping !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ramp got duty=%0d ramp=%0b exp 4/1", duty_value, ramping);
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    target_value = '0;
    model_reset();
    test_reset();
    test_soft_start();
    test_partial_step();
    test_reversal();
    test_disable();
    test_enable_toggle();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
